// File: rtl/if_fetch_ctrl.sv
// Purpose : instruction-fetch sequencer; owns the PC, drives imem read and fills the IF/ID register.
// Latency : the word at PC=A lands on instr_o one rising edge after A is presented unstalled.
// Backpr. : stall_i freezes PC and IF/ID (rd_en drops); flush_i overrides stall and squashes IF/ID.
//
// Ports:
//   clk_i, rst_i (async, active-high)         clock and reset
//   stall_i, flush_i, target_i                pipeline hold / redirect control
//   imem_rd_en_o, imem_addr_o, imem_data_i    combinational instruction memory port
//   instr_o, pc_o, valid_o                    IF/ID pipeline register
//   fetch_cnt_o                               saturating count of captured instructions
//   halted_o                                  fetch halted (only with IF_FETCH_HALT_EN)
//
// Build option: define IF_FETCH_HALT_EN to stop fetching when HALT_WORD is read.
module if_fetch_ctrl #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 5,
    parameter logic [DEPTH-1:0]   RESET_PC  = '0,
    parameter logic [WIDTH-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [DEPTH-1:0] target_i,
    output logic             imem_rd_en_o,
    output logic [DEPTH-1:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_data_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [DEPTH-1:0] pc_o,
    output logic             valid_o,
    output logic [15:0]      fetch_cnt_o,
    output logic             halted_o
);

`ifdef IF_FETCH_HALT_EN
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   instr_q, instr_d;
    logic [DEPTH-1:0]   pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic [15:0]        fetch_cnt_q, fetch_cnt_d;
    logic               halted_q, halted_d;
    logic               halt_hit;

    // State register and all datapath flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            pc_out_q    <= '0;
            valid_q     <= 1'b0;
            fetch_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            halted_q    <= halted_d;
        end
    end

`ifdef IF_FETCH_HALT_EN
    assign halt_hit = (imem_data_i == HALT_WORD);
`else
    // Halt detection is compiled out; HALT_WORD is fetched like any other word.
    assign halt_hit = 1'b0;
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
`endif

    // Next-state and datapath update. Priority inside RUN: flush > stall > capture.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        fetch_cnt_d = fetch_cnt_q;
        halted_d    = halted_q;
        unique case (state_q)
            BOOT: begin
                // One idle cycle after reset; stall/flush are not looked at here.
                state_d = RUN;
            end
            RUN: begin
                if (flush_i) begin
                    // Redirect: squash IF/ID to a NOP; pc_o keeps the last captured address.
                    pc_d    = target_i;
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    if (halt_hit) begin
`ifdef IF_FETCH_HALT_EN
                        state_d = HALT;
`endif
                        // PC parks on the halt address, nothing is counted.
                        instr_d  = '0;
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        instr_d  = imem_data_i;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        // Natural wrap from 2**DEPTH-1 to 0.
                        pc_d     = pc_q + DEPTH'(1);
                        if (fetch_cnt_q != 16'hFFFF) begin
                            fetch_cnt_d = fetch_cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: begin
                // HALT: sticky until reset.
                state_d = state_q;
            end
        endcase
    end

    // Outputs. rd_en is combinational on stall_i so a stalled cycle never reads.
    always_comb begin
        imem_rd_en_o = !rst_i && (state_q == RUN) && !stall_i;
        imem_addr_o  = pc_q;
        instr_o      = instr_q;
        pc_o         = pc_out_q;
        valid_o      = valid_q;
        fetch_cnt_o  = fetch_cnt_q;
`ifdef IF_FETCH_HALT_EN
        halted_o     = halted_q;
`else
        halted_o     = 1'b0;
`endif
    end

`ifndef IF_FETCH_HALT_EN
    logic unused_halted;
    assign unused_halted = halted_q;
`endif

endmodule
